fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory
//   word address, and registers {valid, inst, pc, pc+4} into the IF/ID register.
//   The ID decoder consumes id_inst, and ID branch/jump resolution returns redirect_*.
//   Branch delay slot architected: a redirect does NOT squash the instruction fetched that cycle.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC loaded on reset; base of instruction memory
//   IM_AW     10             imem word-address width (imem holds 2**IM_AW words)
// PORTS
//   clk             in   1      rising-edge clock
//   rst_n           in   1      asynchronous active-low reset
//   stall           in   1      hazard unit: hold PC and IF/ID contents
//   flush           in   1      load a bubble into IF/ID (valid=0, inst=NOP)
//   redirect_valid  in   1      ID resolved taken beq / jal
//   redirect_pc     in   32     target PC for redirect
//   imem_addr       out  IM_AW  word address to imem (combinational read)
//   imem_rdata      in   32     instruction word at imem_addr, same cycle
//   id_valid        out  1      IF/ID holds a real instruction
//   id_inst         out  32     IF/ID instruction (32'h0 when invalid)
//   id_pc           out  32     PC of id_inst
//   id_pc4          out  32     id_pc + 4
//   fetch_fault     out  1      sticky: PC left imem range or was misaligned
// BEHAVIOUR
//   - Reset (async assert, sync-released by clk edge): pc=RESET_PC, state=BOOT, id_valid=0,
//     id_inst=0, id_pc=0, id_pc4=0, fetch_fault=0.
//   - FSM: BOOT -> RUN on the first clk after rst_n=1 (no IF/ID load in BOOT; PC holds).
//     RUN -> FAULT when the current pc is out of range or pc[1:0]!=0 and stall=0.
//     FAULT is terminal until reset: PC frozen, IF/ID loads bubbles, fetch_fault=1.
//   - imem_addr = pc[IM_AW+1:2] - RESET_PC[IM_AW+1:2] (mod 2**IM_AW); combinational.
//   - In range: RESET_PC <= pc < RESET_PC + 4*2**IM_AW (unsigned 32-bit compare).
//   - Next PC in RUN, priority high->low: redirect_valid -> redirect_pc;
//     stall -> pc; else pc+4 (mod 2**32, wraps silently; range check then faults).
//     Redirect wins over stall (the hazard unit never asserts both for one instruction).
//   - IF/ID in RUN, priority: flush -> bubble; stall -> hold; else
//     {1, imem_rdata, pc, pc+4}. A fault fetch loads a bubble, not imem_rdata.
//   - flush and stall together: bubble loads and PC holds.
//   - redirect without stall/flush: the delay-slot instruction (current pc) enters IF/ID;
//     redirect_pc is fetched next cycle. Latency: redirect at edge N -> id_pc=target at N+2.
//   - Reset mid-operation: all state returns to reset values immediately; no partial writes.
// STRUCTURE
//   - mips_pkg: RESET_PC default, INST_NOP=32'h0, op_* encodings shared with the decoder,
//     fetch FSM state encoding (BOOT/RUN/FAULT).
//   - Sub-module pc_gen: combinational next-PC mux + pc+4 adder + range/alignment check;
//     fetch_stage keeps the PC register, FSM and IF/ID register.
// TESTING
//   1 reset release, no stall: after BOOT, id_pc = 3000,3004,3008 on consecutive cycles;
//     id_valid=1 and id_inst = imem words 0,1,2.
//   2 stall held 3 cycles at pc=300C: id_pc stays 3008, imem_addr stays 3; resumes at 300C.
//   3 redirect_pc=3040 with id_pc=3010: next id_pc=3014 (delay slot), then 3040, 3044.
//   4 flush+stall together at pc=3020: id_valid=0, id_inst=0; next unstalled id_pc=3020.
//   5 redirect_pc=3002 (misaligned) or 0000_2FFC (below base): fetch_fault=1 the cycle
//     after the bad PC is current; IF/ID bubbles forever; PC frozen.
//   6 rst_n pulsed low mid-stream (async, between edges): outputs zero immediately,
//     pc=3000, fetch_fault cleared; sequence restarts as in test 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, NOP, opcodes, fetch FSM states, IF/ID payload.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned IM_AW_DEF    = 10;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, inst: INST_NOP, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port and IF/ID register outputs of the fetch stage.
interface fetch_stage_if #(
  parameter int unsigned IM_AW = 10
);
  logic [IM_AW-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc4;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output id_valid,
    output id_inst,
    output id_pc,
    output id_pc4
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  id_valid,
    input  id_inst,
    input  id_pc,
    input  id_pc4
  );
endinterface

// File: rtl/fetch_stage_pc_gen.sv
// Next-PC selection, pc+4 adder and imem range/alignment check for the fetch stage.
module fetch_stage_pc_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_AW    = IM_AW_DEF
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc_c,
  output logic [31:0] pc4_c,
  output logic        bad_pc_c
);

  // One past the last imem byte; 33 bits so a base near the top cannot overflow.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(1) << (IM_AW + 2));

  assign pc4_c = pc + 32'd4;

  always_comb begin
    next_pc_c = pc4_c;
    if (redirect_valid) begin
      next_pc_c = redirect_pc;
    end else if (stall) begin
      next_pc_c = pc;
    end
  end

  assign bad_pc_c = (pc < RESET_PC) || ({1'b0, pc} >= PC_LIMIT) || (pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, boot/run/fault FSM and IF/ID register; delay slot is never squashed.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_AW    = IM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        bus,
  output logic                 fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  logic         fault_d;

  logic [31:0]  next_pc;
  logic [31:0]  pc4;
  logic         bad_pc;

  fetch_stage_pc_gen #(
    .RESET_PC (RESET_PC),
    .IM_AW    (IM_AW)
  ) u_pc_gen (
    .pc             (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc_c      (next_pc),
    .pc4_c          (pc4),
    .bad_pc_c       (bad_pc)
  );

  // Word address relative to the imem base, wrapping within the imem size.
  assign bus.imem_addr = pc_q[IM_AW+1:2] - RESET_PC[IM_AW+1:2];

  assign bus.id_valid = ifid_q.valid;
  assign bus.id_inst  = ifid_q.inst;
  assign bus.id_pc    = ifid_q.pc;
  assign bus.id_pc4   = ifid_q.pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      ifid_q      <= IFID_BUBBLE;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      fetch_fault <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    fault_d = fetch_fault;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bad_pc && !stall) begin
          // A bad fetch never reaches ID; the PC freezes on the offending address.
          state_d = ST_FAULT;
          fault_d = 1'b1;
          ifid_d  = IFID_BUBBLE;
        end else begin
          pc_d = next_pc;
          if (flush) begin
            ifid_d = IFID_BUBBLE;
          end else if (!stall) begin
            ifid_d = '{valid: 1'b1, inst: bus.imem_rdata, pc: pc_q, pc4: pc4};
          end
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
        ifid_d  = IFID_BUBBLE;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an imem model whose word i reads as A000_0000 + i.
module tb_fetch_stage;

  localparam int unsigned IM_AW = 10;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_stage_if #(.IM_AW(IM_AW)) bus ();

  assign bus.imem_rdata = 32'hA000_0000 | 32'(bus.imem_addr);

  fetch_stage #(
    .RESET_PC (32'h0000_3000),
    .IM_AW    (IM_AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_id(input string tag, input logic [31:0] pc);
    check({tag, " valid"}, 32'(bus.id_valid), 32'd1);
    check({tag, " pc"},    bus.id_pc, pc);
    check({tag, " pc4"},   bus.id_pc4, pc + 32'd4);
    check({tag, " inst"},  bus.id_inst, 32'hA000_0000 + ((pc - 32'h3000) >> 2));
  endtask

  task automatic expect_zero(input string tag);
    check({tag, " valid"}, 32'(bus.id_valid), 32'd0);
    check({tag, " inst"},  bus.id_inst, 32'd0);
    check({tag, " pc"},    bus.id_pc, 32'd0);
    check({tag, " pc4"},   bus.id_pc4, 32'd0);
    check({tag, " fault"}, 32'(fetch_fault), 32'd0);
    check({tag, " addr"},  32'(bus.imem_addr), 32'd0);
  endtask

  // Async reset pulse between edges; outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 expect_zero(tag);
    #2 rst_n = 1'b1;
  endtask

  // Boot edge then two fetches: id_pc 3000, 3004.
  task automatic boot_seq(input string tag);
    step();
    check({tag, " boot bubble"}, 32'(bus.id_valid), 32'd0);
    step(); expect_id({tag, " f0"}, 32'h3000);
    step(); expect_id({tag, " f1"}, 32'h3004);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1 expect_zero("reset");
    step();
    expect_zero("reset held");
    rst_n = 1'b1;

    // Test 1: straight-line fetch after boot
    boot_seq("t1");
    step(); expect_id("t1 f2", 32'h3008);
    check("t1 addr", 32'(bus.imem_addr), 32'd3);

    // Test 2: stall 3 cycles at pc=300C
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2 hold pc", bus.id_pc, 32'h3008);
      check("t2 hold addr", 32'(bus.imem_addr), 32'd3);
    end
    stall = 1'b0;
    step(); expect_id("t2 resume", 32'h300C);

    // Test 3: redirect to 3040 while id_pc=3010; delay slot 3014 still enters
    step(); expect_id("t3 pre", 32'h3010);
    redirect_valid = 1'b1; redirect_pc = 32'h3040;
    step(); expect_id("t3 slot", 32'h3014);
    redirect_valid = 1'b0;
    step(); expect_id("t3 tgt", 32'h3040);
    step(); expect_id("t3 tgt+4", 32'h3044);

    // Test 4: flush+stall at pc=3020
    redirect_valid = 1'b1; redirect_pc = 32'h3020;
    step(); expect_id("t4 slot", 32'h3048);
    redirect_valid = 1'b0; flush = 1'b1; stall = 1'b1;
    step();
    check("t4 bubble valid", 32'(bus.id_valid), 32'd0);
    check("t4 bubble inst", bus.id_inst, 32'd0);
    check("t4 pc held", 32'(bus.imem_addr), 32'd8);
    flush = 1'b0; stall = 1'b0;
    step(); expect_id("t4 resume", 32'h3020);

    // Test 5a: misaligned redirect to 3002
    redirect_valid = 1'b1; redirect_pc = 32'h3002;
    step(); expect_id("t5 slot", 32'h3024);
    check("t5 no fault yet", 32'(fetch_fault), 32'd0);
    redirect_valid = 1'b0;
    step();
    check("t5 fault", 32'(fetch_fault), 32'd1);
    check("t5 bubble", 32'(bus.id_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5 sticky", 32'(fetch_fault), 32'd1);
      check("t5 frozen addr", 32'(bus.imem_addr), 32'd0);
      check("t5 still bubble", 32'(bus.id_valid), 32'd0);
      check("t5 bubble inst", bus.id_inst, 32'd0);
    end
    redirect_valid = 1'b0;

    // Test 6: async reset clears fault, sequence restarts; then reset with live data
    reset_pulse("t6 rst fault");
    boot_seq("t6 restart");
    reset_pulse("t6 rst live");
    boot_seq("t6 restart2");

    // Test 5b: redirect below base (2FFC)
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2FFC;
    step(); expect_id("t5b slot", 32'h3008);
    check("t5b no fault yet", 32'(fetch_fault), 32'd0);
    check("t5b addr wrap", 32'(bus.imem_addr), 32'd1023);
    redirect_valid = 1'b0;
    step();
    check("t5b fault", 32'(fetch_fault), 32'd1);
    check("t5b bubble", 32'(bus.id_valid), 32'd0);
    step();
    check("t5b frozen addr", 32'(bus.imem_addr), 32'd1023);
    check("t5b sticky", 32'(fetch_fault), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
